// File: rtl/fifo_level.sv
// Synchronous show-ahead FIFO with occupancy level, watermarks and flush.
// Optional sticky overflow/underflow flags are built when FIFO_ERR_STICKY_EN is defined.
module fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clr,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       push,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  push_acc;
  logic                  pop_acc;

  // push/pop are requests with no ready return: a pop is honoured only when
  // not empty, a push only when not full or when a pop frees a slot this cycle.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  // Flags decode the registered level, so they follow the edge by one cycle.
  assign full         = (level == LW'(DEPTH));
  assign empty        = (level == '0);
  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  assign dout = ram[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push_acc) - LW'(pop_acc);
    end
  end

  // Storage is not reset; a flush leaves old contents in place.
  always_ff @(posedge clk) begin
    if (push_acc && !clr) ram[wr_ptr] <= din;
  end

`ifdef FIFO_ERR_STICKY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // A new error in the same cycle as err_clr keeps the flag set.
      if (push && !push_acc)  overflow <= 1'b1;
      else if (err_clr)       overflow <= 1'b0;
      if (pop && empty)       underflow <= 1'b1;
      else if (err_clr)       underflow <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// Directed table-driven bench for fifo_level (DEPTH=4, AF=3, AE=1),
// plus hand-written wrap and asynchronous-reset sequences.
module tb_fifo_level;

  logic       clk;
  logic       resetn;
  logic       clr;
  logic [7:0] din;
  logic       push;
  logic       pop;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] level;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

`ifdef FIFO_ERR_STICKY_EN
  localparam logic EN = 1'b1;
`else
  localparam logic EN = 1'b0;
`endif

  fifo_level #(
    .DATA_WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)
  ) dut (
    .clk(clk), .resetn(resetn), .clr(clr), .din(din), .push(push), .pop(pop),
    .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       clr, push, pop, err_clr;
    logic [7:0] din;
    logic [2:0] lvl;
    logic       chk;
    logic [7:0] dout;
    logic [3:0] flags; // {full, empty, almost_full, almost_empty}
    logic [1:0] errs;  // {overflow, underflow} in the sticky build
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic c, input logic pu, input logic po, input logic ec,
                              input logic [7:0] d, input logic [2:0] l, input logic ck,
                              input logic [7:0] o, input logic [3:0] f, input logic [1:0] e);
    vec_t v;
    v.clr = c; v.push = pu; v.pop = po; v.err_clr = ec; v.din = d;
    v.lvl = l; v.chk = ck; v.dout = o; v.flags = f; v.errs = e;
    vecs.push_back(v);
  endfunction

  task automatic idle();
    clr = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = 8'h00;
  endtask

  task automatic check_state(input string tag, input logic [2:0] l, input logic [3:0] f,
                             input logic [1:0] e);
    check({tag, " level"}, 32'(level), 32'(l));
    check({tag, " flags"}, 32'({full, empty, almost_full, almost_empty}), 32'(f));
    check({tag, " errs"}, 32'({overflow, underflow}), 32'(e & {EN, EN}));
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 3'd0, 4'b0101, 2'b00);
    #2 resetn = 1'b1;

    //   clr push pop ec  din     lvl  chk dout    f/e/af/ae errs
    // fill, overflow, drain
    add(0, 1, 0, 0, 8'hA1, 3'd1, 1, 8'hA1, 4'b0001, 2'b00);
    add(0, 1, 0, 0, 8'hA2, 3'd2, 1, 8'hA1, 4'b0000, 2'b00);
    add(0, 1, 0, 0, 8'hA3, 3'd3, 1, 8'hA1, 4'b0010, 2'b00);
    add(0, 1, 0, 0, 8'hA4, 3'd4, 1, 8'hA1, 4'b1010, 2'b00);
    add(0, 1, 0, 0, 8'hEE, 3'd4, 1, 8'hA1, 4'b1010, 2'b10);
    add(0, 0, 1, 0, 8'h00, 3'd3, 1, 8'hA2, 4'b0010, 2'b10);
    add(0, 0, 0, 1, 8'h00, 3'd3, 1, 8'hA2, 4'b0010, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd2, 1, 8'hA3, 4'b0000, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd1, 1, 8'hA4, 4'b0001, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd0, 0, 8'h00, 4'b0101, 2'b00);
    // underflow, push+pop while empty
    add(0, 0, 1, 0, 8'h00, 3'd0, 0, 8'h00, 4'b0101, 2'b01);
    add(0, 1, 1, 0, 8'h55, 3'd1, 1, 8'h55, 4'b0001, 2'b01);
    add(0, 0, 0, 1, 8'h00, 3'd1, 1, 8'h55, 4'b0001, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd0, 0, 8'h00, 4'b0101, 2'b00);
    // full with simultaneous push and pop
    add(0, 1, 0, 0, 8'hA1, 3'd1, 1, 8'hA1, 4'b0001, 2'b00);
    add(0, 1, 0, 0, 8'hA2, 3'd2, 1, 8'hA1, 4'b0000, 2'b00);
    add(0, 1, 0, 0, 8'hA3, 3'd3, 1, 8'hA1, 4'b0010, 2'b00);
    add(0, 1, 0, 0, 8'hA4, 3'd4, 1, 8'hA1, 4'b1010, 2'b00);
    add(0, 1, 1, 0, 8'hB5, 3'd4, 1, 8'hA2, 4'b1010, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd3, 1, 8'hA3, 4'b0010, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd2, 1, 8'hA4, 4'b0000, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd1, 1, 8'hB5, 4'b0001, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd0, 0, 8'h00, 4'b0101, 2'b00);
    // clr beats a simultaneous push
    add(0, 1, 0, 0, 8'h11, 3'd1, 1, 8'h11, 4'b0001, 2'b00);
    add(0, 1, 0, 0, 8'h22, 3'd2, 1, 8'h11, 4'b0000, 2'b00);
    add(0, 1, 0, 0, 8'h33, 3'd3, 1, 8'h11, 4'b0010, 2'b00);
    add(1, 1, 0, 0, 8'h44, 3'd0, 0, 8'h00, 4'b0101, 2'b00);
    add(0, 1, 0, 0, 8'h66, 3'd1, 1, 8'h66, 4'b0001, 2'b00);
    add(0, 0, 1, 0, 8'h00, 3'd0, 0, 8'h00, 4'b0101, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      clr = vecs[i].clr; push = vecs[i].push; pop = vecs[i].pop;
      err_clr = vecs[i].err_clr; din = vecs[i].din;
      @(posedge clk);
      #1;
      check_state($sformatf("v%0d", i), vecs[i].lvl, vecs[i].flags, vecs[i].errs);
      if (vecs[i].chk) check($sformatf("v%0d dout", i), 32'(dout), 32'(vecs[i].dout));
    end
    idle();

    // wrap: steady push+pop at level 2
    for (int i = 0; i < 2; i++) begin
      push = 1'b1; din = 8'h70 + 8'(i);
      exp_q.push_back(din);
      @(posedge clk);
      #1;
    end
    idle();
    check("wrap start level", 32'(level), 32'd2);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("wrap%0d dout", i), 32'(dout), 32'(exp_q[0]));
      push = 1'b1; pop = 1'b1; din = 8'h80 + 8'(i);
      exp_q.push_back(din);
      void'(exp_q.pop_front());
      @(posedge clk);
      #1;
      check($sformatf("wrap%0d level", i), 32'(level), 32'd2);
    end
    idle();
    check("wrap end dout", 32'(dout), 32'(exp_q[0]));

    // asynchronous reset mid-stream, between clock edges
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check_state("async reset", 3'd0, 4'b0101, 2'b00);
    #5 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_state("post reset", 3'd0, 4'b0101, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
